// File: rtl/mod3_pkg.sv
// Shared encodings and the residue recurrence for the mod-3 stream scheduler.
// A word is consumed MSB-first, so each new bit updates r to (2r + b) mod 3.
package mod3_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    // Next residue after appending bit b below a prefix whose residue is r.
    function automatic logic [1:0] mod3_next(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            R0:      n = b ? R1 : R0;
            R1:      n = b ? R0 : R2;
            R2:      n = b ? R2 : R1;
            default: n = R0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_residue_fsm.sv
// Three-state serial residue machine: tracks (value so far) mod 3, MSB first.
// A synchronous clear wins over the shift enable.
module mod3_residue_fsm
    import mod3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] residue
);

    logic [1:0] state_r;
    logic [1:0] state_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= R0;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = R0;
        end else if (en) begin
            state_s = mod3_next(state_r, bit_in);
        end else begin
            state_s = state_r;
        end
    end

    // Output logic.
    always_comb begin
        residue = state_r;
    end

endmodule

// File: rtl/mod3_stream_scheduler.sv
// Two-requester round-robin front end feeding a serial mod-3 residue machine.
// One word in flight; result strobe one cycle after the last bit is consumed.
module mod3_stream_scheduler
    import mod3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_div3,
    output logic [1:0]       res_residue,
    output logic             res_id,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic             last_r;
    logic             grant_s;
    logic             req0_ready_s;
    logic             req1_ready_s;
    logic             accept_s;
    logic             shift_en_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             id_r;
    logic [1:0]       fsm_residue_s;
    logic [1:0]       final_residue_s;
    logic             res_valid_r;
    logic             res_div3_r;
    logic [1:0]       res_residue_r;
    logic             res_id_r;
    logic             busy_r;

    assign accept_s        = (req0_valid && req0_ready_s) || (req1_valid && req1_ready_s);
    assign word_s          = grant_s ? req1_data : req0_data;
    assign shift_en_s      = (state_r == SHIFT);
    assign last_bit_s      = shift_en_s && (cnt_r == CNT_ZERO);
    // The residue register only settles on the DONE edge, so fold in the final bit here.
    assign final_residue_s = mod3_next(fsm_residue_s, shreg_r[WIDTH-1]);

    mod3_residue_fsm u_residue_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s),
        .en      (shift_en_s),
        .bit_in  (shreg_r[WIDTH-1]),
        .residue (fsm_residue_s)
    );

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Control next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? SHIFT : IDLE;
            SHIFT:   state_s = (cnt_r == CNT_ZERO) ? DONE : SHIFT;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Round-robin grant and ready outputs; ties go to the requester that was not served last.
    always_comb begin
        grant_s      = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_s      = ~last_r;
                req0_ready_s = last_r;
                req1_ready_s = ~last_r;
            end else if (req0_valid) begin
                grant_s      = 1'b0;
                req0_ready_s = 1'b1;
            end else if (req1_valid) begin
                grant_s      = 1'b1;
                req1_ready_s = 1'b1;
            end else begin
                grant_s = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    // Word capture, pointer update, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            id_r    <= 1'b0;
            last_r  <= 1'b1;
        end else if (accept_s) begin
            shreg_r <= word_s;
            cnt_r   <= CNT_LOAD;
            id_r    <= grant_s;
            last_r  <= grant_s;
        end else if (shift_en_s) begin
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            if (cnt_r != CNT_ZERO) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // Result registers, loaded on the edge entering DONE and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r   <= 1'b0;
            res_div3_r    <= 1'b0;
            res_residue_r <= 2'd0;
            res_id_r      <= 1'b0;
        end else begin
            res_valid_r <= last_bit_s;
            if (last_bit_s) begin
                res_residue_r <= final_residue_s;
                res_div3_r    <= (final_residue_s == R0);
                res_id_r      <= id_r;
            end
        end
    end

    // Busy flag: set on accept, cleared on the DONE to IDLE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
        end else if (accept_s) begin
            busy_r <= 1'b1;
        end else if (state_r == DONE) begin
            busy_r <= 1'b0;
        end
    end

    assign req0_ready  = req0_ready_s;
    assign req1_ready  = req1_ready_s;
    assign res_valid   = res_valid_r;
    assign res_div3    = res_div3_r;
    assign res_residue = res_residue_r;
    assign res_id      = res_id_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mod3_stream_scheduler.sv
// Scoreboard bench for mod3_stream_scheduler: the driver predicts grants and
// results from the arbitration rules and word % 3; a monitor checks each strobe.
module tb_mod3_stream_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         res_valid;
    logic         res_div3;
    logic [1:0]   res_residue;
    logic         res_id;
    logic         busy;

    typedef struct {
        int res;
        int id;
        int edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   next_free = 0;
    int   acc_edge = -100;
    logic m_last = 1'b1;
    int   held_res = 0;
    int   held_div = 0;
    int   held_id = 0;

    mod3_stream_scheduler #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_div3    (res_div3),
        .res_residue (res_residue),
        .res_id      (res_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, expv, edge_cnt);
        end
    endtask

    // One clock cycle of stimulus plus reference-model arbitration.
    task automatic cycle(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1);
        logic idle;
        logic any;
        logic g;
        int   e;
        exp_t ex;
        @(negedge clk);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #1;
        e    = edge_cnt + 1;
        idle = (e >= next_free);
        any  = v0 | v1;
        g    = (v0 && v1) ? ~m_last : ~v0;
        chk("req0_ready", int'(req0_ready), int'(idle && any && !g));
        chk("req1_ready", int'(req1_ready), int'(idle && any && g));
        @(posedge clk);
        if (idle && any) begin
            ex.res    = (g ? int'(d1) : int'(d0)) % 3;
            ex.id     = int'(g);
            ex.edge_n = e + W;
            exp_q.push_back(ex);
            m_last    = g;
            next_free = e + W + 2;
            acc_edge  = e;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_residue", int'(res_residue), 0);
        chk("rst_res_div3", int'(res_div3), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
    endtask

    // Asynchronous reset asserted between clock edges; the in-flight word is dropped.
    task automatic do_reset();
        @(negedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_last    = 1'b1;
        next_free = 0;
        acc_edge  = -100;
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: compare each result strobe with the scoreboard; check busy and holding.
    always @(negedge clk) begin : monitor
        exp_t ex;
        if (!rst) begin
            held_res = 0;
            held_div = 0;
            held_id  = 0;
        end else begin
            chk("busy", int'(busy), int'(edge_cnt >= acc_edge && edge_cnt <= acc_edge + W));
            if (res_valid) begin
                chk("res_valid_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    chk("res_residue", int'(res_residue), ex.res);
                    chk("res_div3", int'(res_div3), int'(ex.res == 0));
                    chk("res_id", int'(res_id), ex.id);
                    chk("strobe_edge", edge_cnt, ex.edge_n);
                end
                held_res = int'(res_residue);
                held_div = int'(res_div3);
                held_id  = int'(res_id);
            end else begin
                chk("hold_residue", int'(res_residue), held_res);
                chk("hold_div3", int'(res_div3), held_div);
                chk("hold_id", int'(res_id), held_id);
            end
        end
    end

    initial begin
        #1;
        rst = 1'b0;
        #2;
        check_reset_outputs();
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Single requests from each side.
        cycle(1'b1, 8'h1B, 1'b0, '0);
        idle_cycles(W + 2);
        cycle(1'b0, '0, 1'b1, 8'h0B);
        idle_cycles(W + 2);

        // Contention straight out of reset, valids held so service alternates.
        do_reset();
        for (int i = 0; i < 4 * (W + 2); i++) cycle(1'b1, 8'h03, 1'b1, 8'h04);
        idle_cycles(W + 2);

        // Boundary words, back to back at full throughput.
        cycle(1'b1, 8'hFF, 1'b0, '0);
        idle_cycles(W + 1);
        cycle(1'b1, 8'h00, 1'b0, '0);
        idle_cycles(W + 1);
        cycle(1'b1, 8'h80, 1'b0, '0);
        idle_cycles(W + 2);

        // Reset three bits into a word, then a fresh word.
        cycle(1'b1, 8'h1B, 1'b0, '0);
        idle_cycles(3);
        do_reset();
        cycle(1'b1, 8'h05, 1'b0, '0);
        idle_cycles(W + 2);

        // Valid pulses while the datapath is busy.
        cycle(1'b1, 8'h07, 1'b0, '0);
        for (int i = 0; i < W + 4; i++) cycle(1'(i % 2), 8'h22, 1'b0, '0);
        idle_cycles(W + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle_cycles(W + 4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
